// File: rtl/ocx_afu_cmd_credit_queue.sv
// AFU command queue with TLX command/data credit tracking; issues head commands when credits allow and forwards write flits in order.
// Optional stall statistics counter enabled by OCX_CMD_CREDIT_STATS_EN.
module ocx_afu_cmd_credit_queue #(
  parameter int CMD_FIFO_DEPTH = 8,
  parameter int MISC_W         = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              up_cmd_valid,
  output logic              up_cmd_ready,
  input  logic [7:0]        up_cmd_opcode,
  input  logic [15:0]       up_cmd_afutag,
  input  logic [67:0]       up_cmd_ea_or_obj,
  input  logic [1:0]        up_cmd_dl,
  input  logic              up_cmd_has_data,
  input  logic [MISC_W-1:0] up_cmd_misc,
  input  logic              up_data_valid,
  output logic              up_data_ready,
  input  logic [511:0]      up_data_bus,
  input  logic              up_data_bdi,
  input  logic [3:0]        tlx_afu_cmd_initial_credit,
  input  logic [5:0]        tlx_afu_cmd_data_initial_credit,
  input  logic              tlx_afu_cmd_credit,
  input  logic              tlx_afu_cmd_data_credit,
  output logic              afu_tlx_cmd_valid,
  output logic [7:0]        afu_tlx_cmd_opcode,
  output logic [15:0]       afu_tlx_cmd_afutag,
  output logic [67:0]       afu_tlx_cmd_ea_or_obj,
  output logic [1:0]        afu_tlx_cmd_dl,
  output logic [MISC_W-1:0] afu_tlx_cmd_misc,
  output logic              afu_tlx_cdata_valid,
  output logic [511:0]      afu_tlx_cdata_bus,
  output logic              afu_tlx_cdata_bdi,
  output logic              credit_err
`ifdef OCX_CMD_CREDIT_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int AW = $clog2(CMD_FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]        opcode;
    logic [15:0]       afutag;
    logic [67:0]       ea;
    logic [1:0]        dl;
    logic              has_data;
    logic [MISC_W-1:0] misc;
  } cmd_t;

  typedef enum logic {LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic            run;
  cmd_t            mem_q [CMD_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [4:0]      cmd_cr_q, cmd_cr_d;
  logic [6:0]      dat_cr_q, dat_cr_d;
  logic            err_q, err_d;
  logic [2:0]      owed_q, owed_d;
  logic            iss_vld_q, cmd_vld_q;
  cmd_t            iss_q, out_q;
  logic            cdata_vld_q, cdata_bdi_q;
  logic [511:0]    cdata_bus_q;
  cmd_t            head, up_cmd;
  logic [2:0]      f_head, dat_use;
  logic            head_vld, issue, push, dacc;
  logic [5:0]      cmd_sum;
  logic [7:0]      dat_sum;

  function automatic logic [2:0] flits(input logic hd, input logic [1:0] dl);
    if (!hd) return 3'd0;
    case (dl)
      2'd2:    return 3'd2;
      2'd3:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // FSM: state register / next state / outputs
  always_ff @(posedge clock) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
  end

  always_comb begin
    run           = (state_q == RUN);
    up_cmd_ready  = ready_q;
    up_data_ready = run && (owed_q != 3'd0);
  end

  assign up_cmd  = '{opcode: up_cmd_opcode, afutag: up_cmd_afutag, ea: up_cmd_ea_or_obj,
                     dl: up_cmd_dl, has_data: up_cmd_has_data, misc: up_cmd_misc};
  assign head     = mem_q[rd_ptr_q];
  assign f_head   = flits(head.has_data, head.dl);
  assign head_vld = run && (cnt_q != '0);
  assign issue    = head_vld && (cmd_cr_q != 5'd0) && (dat_cr_q >= {4'd0, f_head}) &&
                    ((f_head == 3'd0) || (owed_q == 3'd0));
  assign push     = up_cmd_valid && ready_q;
  assign dacc     = up_data_valid && up_data_ready;
  assign dat_use  = issue ? f_head : 3'd0;

  always_comb begin
    cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    ready_d = (state_d == RUN) && (cnt_d != CMD_FIFO_DEPTH[AW:0]);
    owed_d  = owed_q + dat_use - {2'd0, dacc};
  end

  // consume and return fold into one update so simultaneous events cancel
  always_comb begin
    cmd_sum  = {1'b0, cmd_cr_q} - {5'd0, issue} + {5'd0, tlx_afu_cmd_credit};
    dat_sum  = {1'b0, dat_cr_q} - {5'd0, dat_use} + {7'd0, tlx_afu_cmd_data_credit};
    cmd_cr_d = cmd_sum[4:0];
    dat_cr_d = dat_sum[6:0];
    err_d    = err_q;
    if (!run) begin
      cmd_cr_d = {1'b0, tlx_afu_cmd_initial_credit};
      dat_cr_d = {1'b0, tlx_afu_cmd_data_initial_credit};
    end else begin
      if (cmd_sum > 6'd16) begin cmd_cr_d = 5'd16; err_d = 1'b1; end
      if (dat_sum > 8'd64) begin dat_cr_d = 7'd64; err_d = 1'b1; end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= up_cmd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      cmd_cr_q    <= '0;
      dat_cr_q    <= '0;
      err_q       <= 1'b0;
      owed_q      <= '0;
      iss_vld_q   <= 1'b0;
      iss_q       <= '0;
      cmd_vld_q   <= 1'b0;
      out_q       <= '0;
      cdata_vld_q <= 1'b0;
      cdata_bus_q <= '0;
      cdata_bdi_q <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      cmd_cr_q  <= cmd_cr_d;
      dat_cr_q  <= dat_cr_d;
      err_q     <= err_d;
      owed_q    <= owed_d;
      iss_vld_q <= issue;
      if (issue) iss_q <= head;
      cmd_vld_q <= iss_vld_q;
      if (iss_vld_q) out_q <= iss_q;
      cdata_vld_q <= dacc;
      if (dacc) begin
        cdata_bus_q <= up_data_bus;
        cdata_bdi_q <= up_data_bdi;
      end
    end
  end

`ifdef OCX_CMD_CREDIT_STATS_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clock) begin
    if (reset)                  stall_cnt_q <= '0;
    else if (head_vld && !issue) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`endif

  assign afu_tlx_cmd_valid     = cmd_vld_q;
  assign afu_tlx_cmd_opcode    = out_q.opcode;
  assign afu_tlx_cmd_afutag    = out_q.afutag;
  assign afu_tlx_cmd_ea_or_obj = out_q.ea;
  assign afu_tlx_cmd_dl        = out_q.dl;
  assign afu_tlx_cmd_misc      = out_q.misc;
  assign afu_tlx_cdata_valid   = cdata_vld_q;
  assign afu_tlx_cdata_bus     = cdata_bus_q;
  assign afu_tlx_cdata_bdi     = cdata_bdi_q;
  assign credit_err            = err_q;

  logic unused_ok;
  assign unused_ok = out_q.has_data;
endmodule

// File: tb/tb_ocx_afu_cmd_credit_queue.sv
// Scoreboard bench for ocx_afu_cmd_credit_queue: commands/flits queued when accepted, checked when issued.
module tb_ocx_afu_cmd_credit_queue;
  logic         clock = 1'b0, reset = 1'b1;
  logic         up_cmd_valid = 0, up_cmd_ready, up_cmd_has_data = 0;
  logic [7:0]   up_cmd_opcode = 0;
  logic [15:0]  up_cmd_afutag = 0;
  logic [67:0]  up_cmd_ea_or_obj = 0;
  logic [1:0]   up_cmd_dl = 0;
  logic [127:0] up_cmd_misc = 0;
  logic         up_data_valid = 0, up_data_ready, up_data_bdi = 0;
  logic [511:0] up_data_bus = 0;
  logic [3:0]   cmd_init = 0;
  logic [5:0]   dat_init = 0;
  logic         cmd_ret = 0, dat_ret = 0;
  logic         afu_tlx_cmd_valid, afu_tlx_cdata_valid, afu_tlx_cdata_bdi, credit_err;
  logic [7:0]   afu_tlx_cmd_opcode;
  logic [15:0]  afu_tlx_cmd_afutag;
  logic [67:0]  afu_tlx_cmd_ea_or_obj;
  logic [1:0]   afu_tlx_cmd_dl;
  logic [127:0] afu_tlx_cmd_misc;
  logic [511:0] afu_tlx_cdata_bus;
`ifdef OCX_CMD_CREDIT_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  ocx_afu_cmd_credit_queue #(.CMD_FIFO_DEPTH(8), .MISC_W(128)) dut (
    .clock(clock), .reset(reset),
    .up_cmd_valid(up_cmd_valid), .up_cmd_ready(up_cmd_ready), .up_cmd_opcode(up_cmd_opcode),
    .up_cmd_afutag(up_cmd_afutag), .up_cmd_ea_or_obj(up_cmd_ea_or_obj), .up_cmd_dl(up_cmd_dl),
    .up_cmd_has_data(up_cmd_has_data), .up_cmd_misc(up_cmd_misc),
    .up_data_valid(up_data_valid), .up_data_ready(up_data_ready), .up_data_bus(up_data_bus),
    .up_data_bdi(up_data_bdi),
    .tlx_afu_cmd_initial_credit(cmd_init), .tlx_afu_cmd_data_initial_credit(dat_init),
    .tlx_afu_cmd_credit(cmd_ret), .tlx_afu_cmd_data_credit(dat_ret),
    .afu_tlx_cmd_valid(afu_tlx_cmd_valid), .afu_tlx_cmd_opcode(afu_tlx_cmd_opcode),
    .afu_tlx_cmd_afutag(afu_tlx_cmd_afutag), .afu_tlx_cmd_ea_or_obj(afu_tlx_cmd_ea_or_obj),
    .afu_tlx_cmd_dl(afu_tlx_cmd_dl), .afu_tlx_cmd_misc(afu_tlx_cmd_misc),
    .afu_tlx_cdata_valid(afu_tlx_cdata_valid), .afu_tlx_cdata_bus(afu_tlx_cdata_bus),
    .afu_tlx_cdata_bdi(afu_tlx_cdata_bdi), .credit_err(credit_err)
`ifdef OCX_CMD_CREDIT_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int cyc = 0, n_iss = 0, n_dat = 0, last1 = 0, last2 = 0;
  logic [519:0] exp_cmd[$];
  logic [519:0] exp_dat[$];

  task automatic chk(input string tag, input logic [519:0] got, input logic [519:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (!reset && afu_tlx_cmd_valid) begin
      n_iss++; last2 = last1; last1 = cyc;
      if (exp_cmd.size() == 0) chk("cmd_extra", 1, 0);
      else chk("cmd_pay", {afu_tlx_cmd_opcode, afu_tlx_cmd_afutag, afu_tlx_cmd_ea_or_obj,
                           afu_tlx_cmd_dl, afu_tlx_cmd_misc}, exp_cmd.pop_front());
    end
    if (!reset && afu_tlx_cdata_valid) begin
      n_dat++;
      if (exp_dat.size() == 0) chk("dat_extra", 1, 0);
      else chk("dat_pay", {afu_tlx_cdata_bdi, afu_tlx_cdata_bus}, exp_dat.pop_front());
    end
  end

  task automatic do_reset(input logic [3:0] c, input logic [5:0] d);
    cmd_init = c; dat_init = d; reset = 1'b1;
    up_cmd_valid = 0; up_data_valid = 0; cmd_ret = 0; dat_ret = 0;
    @(negedge clock); @(negedge clock);
    chk("rst_outs", {afu_tlx_cmd_valid, up_cmd_ready, up_data_ready, afu_tlx_cdata_valid,
                     credit_err, afu_tlx_cmd_opcode, afu_tlx_cmd_afutag}, 0);
    exp_cmd.delete(); exp_dat.delete();
    reset = 1'b0;
    #1 chk("load_rdy0", up_cmd_ready, 0);
    @(negedge clock);
    chk("load_rdy1", up_cmd_ready, 1);
    chk("load_ccr", dut.cmd_cr_q, {1'b0, c});
    chk("load_dcr", dut.dat_cr_q, {1'b0, d});
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [15:0] tg, input logic [67:0] ea,
                          input logic [1:0] dl, input logic hd);
    logic [127:0] m;
    int n;
    m = {$urandom, $urandom, $urandom, $urandom};
    up_cmd_opcode = op; up_cmd_afutag = tg; up_cmd_ea_or_obj = ea; up_cmd_dl = dl;
    up_cmd_has_data = hd; up_cmd_misc = m; up_cmd_valid = 1'b1;
    n = 0;
    while (!up_cmd_ready && n < 50) begin @(negedge clock); n++; end
    if (!up_cmd_ready) chk("push_to", 0, 1);
    else exp_cmd.push_back({op, tg, ea, dl, m});
    @(negedge clock);
    up_cmd_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [511:0] b, input logic bdi);
    int n;
    up_data_bus = b; up_data_bdi = bdi; up_data_valid = 1'b1;
    n = 0;
    while (!up_data_ready && n < 50) begin @(negedge clock); n++; end
    if (!up_data_ready) chk("flit_to", 0, 1);
    else exp_dat.push_back({bdi, b});
    @(negedge clock);
    up_data_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int i0, d0;
    // single no-data command, latency and credit bookkeeping
    do_reset(4'd4, 6'd8);
    i0 = n_iss;
    push_cmd(8'h01, 16'h1234, 68'h1_2345_6789_abcd_ef01, 2'd0, 1'b0);
    @(negedge clock); chk("lat_early", afu_tlx_cmd_valid, 0);
    @(negedge clock); chk("lat_hit", afu_tlx_cmd_valid, 1);
    chk("ccr_4to3", dut.cmd_cr_q, 3);
    chk("dcr_keep8", dut.dat_cr_q, 8);
    @(negedge clock); chk("lat_pulse", afu_tlx_cmd_valid, 0);
    chk("one_issue", n_iss - i0, 1);

    // write with dl=3: four flits with gaps
    i0 = n_iss; d0 = n_dat;
    push_cmd(8'h20, 16'h0bee, 68'h0_0000_0000_1000_0000, 2'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_flit({16{$urandom}}, k[0]);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    chk("wr_iss", n_iss - i0, 1);
    chk("wr_flits", n_dat - d0, 4);
    chk("dcr_8to4", dut.dat_cr_q, 4);
    chk("owed_0", dut.owed_q, 0);
    chk("ccr_3to2", dut.cmd_cr_q, 2);

    // credit starvation then recovery
    do_reset(4'd1, 6'd8);
    i0 = n_iss;
    push_cmd(8'h10, 16'd1, 68'd100, 2'd0, 1'b0);
    push_cmd(8'h11, 16'd2, 68'd200, 2'd1, 1'b0);
    push_cmd(8'h12, 16'd3, 68'd300, 2'd2, 1'b0);
    repeat (6) @(negedge clock);
    chk("starve_iss", n_iss - i0, 1);
    cmd_ret = 1'b1;
    @(negedge clock); @(negedge clock);
    cmd_ret = 1'b0;
    repeat (6) @(negedge clock);
    chk("recov_iss", n_iss - i0, 3);
    chk("recov_b2b", last1 - last2, 1);
    chk("recov_ccr", dut.cmd_cr_q, 0);

    // simultaneous return and consume
    do_reset(4'd2, 6'd8);
    i0 = n_iss;
    push_cmd(8'h30, 16'd7, 68'd7, 2'd0, 1'b0);
    cmd_ret = 1'b1;
    @(negedge clock);
    cmd_ret = 1'b0;
    chk("sim_ccr", dut.cmd_cr_q, 2);
    repeat (3) @(negedge clock);
    chk("sim_iss", n_iss - i0, 1);

    // data credit saturation
    do_reset(4'd0, 6'd63);
    dat_ret = 1'b1;
    @(negedge clock);
    chk("dsat_64", dut.dat_cr_q, 64);
    chk("dsat_noerr", credit_err, 0);
    @(negedge clock);
    dat_ret = 1'b0;
    chk("dsat_hold", dut.dat_cr_q, 64);
    chk("dsat_err", credit_err, 1);

    // command credit saturation: 17 returns on initial 0
    do_reset(4'd0, 6'd0);
    chk("err_clr", credit_err, 0);
    cmd_ret = 1'b1;
    repeat (16) @(negedge clock);
    chk("csat_16", dut.cmd_cr_q, 16);
    chk("csat_noerr", credit_err, 0);
    @(negedge clock);
    cmd_ret = 1'b0;
    chk("csat_hold", dut.cmd_cr_q, 16);
    chk("csat_err", credit_err, 1);
    repeat (3) @(negedge clock);
    chk("err_sticky", credit_err, 1);

    // FIFO full with zero credits
    do_reset(4'd0, 6'd0);
    i0 = n_iss;
    for (int k = 0; k < 8; k++) push_cmd(8'h40 + k[7:0], k[15:0], 68'(k), 2'd0, 1'b0);
    chk("full_rdy", up_cmd_ready, 0);
    @(negedge clock);
    chk("full_rdy2", up_cmd_ready, 0);
    chk("full_noiss", n_iss - i0, 0);

    // mid-operation reset with two flits owed
    do_reset(4'd1, 6'd8);
    push_cmd(8'h21, 16'h00aa, 68'hf00, 2'd2, 1'b1);
    push_cmd(8'h50, 16'h00bb, 68'hf40, 2'd0, 1'b0);
    repeat (4) @(negedge clock);
    chk("mid_dready", up_data_ready, 1);
    chk("mid_owed", dut.owed_q, 2);
    do_reset(4'd4, 6'd8);
    i0 = n_iss;
    repeat (6) @(negedge clock);
    chk("post_noiss", n_iss - i0, 0);
    chk("post_dready", up_data_ready, 0);
    chk("post_ccr", dut.cmd_cr_q, 4);

`ifdef OCX_CMD_CREDIT_STATS_EN
    do_reset(4'd0, 6'd8);
    push_cmd(8'h60, 16'd9, 68'd9, 2'd0, 1'b0);
    repeat (10) @(negedge clock);
    chk("stall_10", stall_cnt, 10);
`endif

    do_reset(4'd0, 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ocx_afu_cmd_credit_queue.md
Name: ocx_afu_cmd_credit_queue

Overview:
- Upstream stage of the OCSE3-to-OCSE4 bridge, on the AFU command path. Feeds the OCSE3 afu_tlx cmd/cdata interface, which the bridge maps onto VC3/DCP3.
- Buffers AFU commands in a FIFO and tracks TLX command and data credits. Issues a command only when enough credits are available, then streams the associated data flits in order.

Parameters:
- CMD_FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2.
- MISC_W, 128, width of opaque side-band per command (actag, pasid, bdf, be, pl, etc.), carried unchanged.

Ports:
- clock  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- up_cmd_valid  in  1  upstream command valid.
- up_cmd_ready  out  1  FIFO can accept; transfer occurs when valid and ready are both high.
- up_cmd_opcode  in  8  command opcode.
- up_cmd_afutag  in  16  AFU tag.
- up_cmd_ea_or_obj  in  68  effective address or object handle.
- up_cmd_dl  in  2  data length.
- up_cmd_has_data  in  1  command carries write data.
- up_cmd_misc  in  MISC_W  opaque side-band.
- up_data_valid  in  1  upstream write-data flit valid.
- up_data_ready  out  1  flit accepted this cycle.
- up_data_bus  in  512  data flit.
- up_data_bdi  in  1  bad-data indicator.
- tlx_afu_cmd_initial_credit  in  4  initial command credits.
- tlx_afu_cmd_data_initial_credit  in  6  initial data credits.
- tlx_afu_cmd_credit  in  1  return one command credit (pulse).
- tlx_afu_cmd_data_credit  in  1  return one data credit (pulse).
- afu_tlx_cmd_valid  out  1  command issue strobe.
- afu_tlx_cmd_opcode  out  8
- afu_tlx_cmd_afutag  out  16
- afu_tlx_cmd_ea_or_obj  out  68
- afu_tlx_cmd_dl  out  2
- afu_tlx_cmd_misc  out  MISC_W
- afu_tlx_cdata_valid  out  1  data flit strobe.
- afu_tlx_cdata_bus  out  512
- afu_tlx_cdata_bdi  out  1
- credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset: all outputs 0, except up_cmd_ready = 0 and up_data_ready = 0. FIFO empty; credit counters 0; owed-flit count 0; state LOAD.
- FSM LOAD: first cycle after reset deasserts.
  - cmd_cr <= tlx_afu_cmd_initial_credit, zero-extended to 5 bits.
  - dat_cr <= tlx_afu_cmd_data_initial_credit, zero-extended to 7 bits.
  - Go to RUN. LOAD lasts exactly 1 cycle; there are no other transitions. Reset in any state returns to LOAD and discards the FIFO and the owed count.
- RUN:
  - up_cmd_ready = FIFO not full.
  - Flit count f = has_data ? (dl 0→1, 1→1, 2→2, 3→4) : 0.
- Issue condition, evaluated on the FIFO head: head present AND cmd_cr ≥ 1 AND dat_cr ≥ f AND (f == 0 OR owed == 0).
  - On issue, register afu_tlx_cmd_* from the head and pop it.
  - afu_tlx_cmd_valid is high for exactly 1 cycle per command. Payload outputs hold their last value otherwise.
  - cmd_cr decrements by 1, dat_cr by f, and owed <= owed + f.
- Latency: a command written into an empty FIFO with credits available appears on afu_tlx_cmd_valid 2 cycles after the accepting edge. Throughput is 1 command/cycle for no-data commands.
- Data: up_data_ready = (state == RUN) AND (owed > 0).
  - On up_data_valid AND up_data_ready, register the flit to afu_tlx_cdata_*, pulse afu_tlx_cdata_valid for 1 cycle, and decrement owed.
  - Flits are forwarded in command order. The first flit is allowed in the same cycle afu_tlx_cmd_valid is driven; gaps are allowed.
- Credit arithmetic:
  - The next value is cur − consumed + returned, all evaluated in one cycle, so a simultaneous return and consume nets to zero change.
  - Counter limits: cmd_cr max 16, dat_cr max 64. A return that would exceed the limit saturates and sets credit_err.
  - credit_err clears only on reset.
  - Credits returned during LOAD are dropped.
- FIFO full: up_cmd_ready = 0. A same-cycle pop does not re-enable ready in that cycle (registered ready).
- FIFO empty with credits available: outputs idle.
- Credits exhausted: head stalls indefinitely with no loss; ordering is strict, so a stalled data command blocks later no-data commands.

Optional Feature:
- Macro: OCX_CMD_CREDIT_STATS_EN.
- When defined: adds output stall_cnt, 32 bits.
  - Increments each RUN cycle in which the head is present but the issue condition is false. Wraps at 2^32.
  - Resets to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Load, single no-data command: initial credits 4 / 8; push 1 no-data command → afu_tlx_cmd_valid 2 cycles later; cmd_cr 4→3; dat_cr unchanged at 8.
- Write with dl=3: push write, has_data=1, dl=3; supply 4 flits with gaps → cmd issued once; exactly 4 cdata_valid pulses in order; dat_cr 8→4; owed returns to 0.
- Credit starvation: initial cmd credit 1; push 3 no-data commands → 1 issue, then stall. Pulse tlx_afu_cmd_credit twice → remaining 2 issue in order, 1 per cycle.
- Simultaneous return and consume: issue in the same cycle as a tlx_afu_cmd_credit pulse → cmd_cr unchanged. Returning 17 credits on initial 0 → cmd_cr saturates at 16 and credit_err = 1.
- FIFO full and mid-operation reset: push 8 commands with 0 credits → up_cmd_ready = 0. Assert reset with owed = 2 → all outputs 0; state LOAD for 1 cycle; no stale issue afterwards.
- With OCX_CMD_CREDIT_STATS_EN defined: hold 1 command for 10 cycles with cmd credit 0 → stall_cnt = 10.
